// File: rtl/video_frame_grabber.sv
// Single-frame BMP grabber: captures one video frame into RAM in BMP row order
// and streams it back as a byte image (optional header, pixels, row padding).
//
// state   | meaning
// IDLE    | waiting for arm
// WAIT    | counting frame starts until START_FRAME is reached
// CAPTURE | writing active pixels of the selected frame into RAM
// HEADER  | emitting the 54-byte BMP header
// PIXELS  | emitting pixel bytes from RAM
// PAD     | emitting zero padding at the end of a row
// DONE    | image fully accepted, waiting for re-arm
module video_frame_grabber #(
    parameter int IMG_HDISP   = 640,
    parameter int IMG_VDISP   = 480,
    parameter int CHANNELS    = 3,
    parameter int START_FRAME = 1,
    parameter int BOTTOM_UP   = 1,
    parameter int HEADER_EN   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  video_vsync,
    input  logic                  video_hsync,
    input  logic                  video_de,
    input  logic [8*CHANNELS-1:0] video_data,
    input  logic                  arm,
    output logic                  busy,
    output logic                  done,
    output logic                  geom_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_data,
    output logic                  out_last
);

    localparam int ROW   = IMG_HDISP * CHANNELS;
    localparam int PAD   = (4 - ROW % 4) % 4;
    localparam int IMG   = (ROW + PAD) * IMG_VDISP;
    localparam int TOTAL = IMG + 54 * HEADER_EN;
    localparam int DEPTH = IMG_HDISP * IMG_VDISP;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(IMG_HDISP + 2);
    localparam int LW    = $clog2(IMG_VDISP + 2);
    localparam int FW    = $clog2(START_FRAME + 1);
    localparam int BW    = $clog2(TOTAL + 1);
    localparam int KW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PW    = 2;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_CAPTURE, S_HEADER, S_PIXELS, S_PAD, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            vs_q, de_q;
    logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CW-1:0]   col_q, col_d;
    logic [LW-1:0]   line_q, line_d;
    logic            line_err_q, line_err_d;
    logic            geom_err_q, geom_err_d;
    logic            done_q, done_d;
    logic [AW-1:0]   pix_addr_q, pix_addr_d;
    logic [KW-1:0]   chan_q, chan_d;
    logic [PW-1:0]   pad_q, pad_d;
    logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
    logic            gen_done_q, gen_done_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_last_q, out_last_d;

    logic [8*CHANNELS-1:0] ram [DEPTH];
    logic [8*CHANNELS-1:0] ram_rd_q;
    logic                  ram_we;
    logic [AW-1:0]         ram_wa;
    int                    wr_row;

    logic frame_start, de_fall, xfer, streaming, adv, is_last;
    logic unused_hsync;

    assign unused_hsync = video_hsync;
    assign frame_start  = vs_q && !video_vsync;
    assign de_fall      = de_q && !video_de;
    assign xfer         = out_valid_q && out_ready;
    assign streaming    = (state_q == S_HEADER) || (state_q == S_PIXELS) || (state_q == S_PAD);
    assign adv          = streaming && !gen_done_q && (!out_valid_q || out_ready);
    assign is_last      = (byte_cnt_q == BW'(TOTAL - 1));

    // Rows are stored already in emission order, so streaming reads addresses linearly.
    assign wr_row = (BOTTOM_UP != 0) ? (IMG_VDISP - 1 - int'(line_q)) : int'(line_q);
    assign ram_wa = AW'(wr_row * IMG_HDISP + int'(col_q));

    function automatic logic [7:0] hdr_byte(input logic [BW-1:0] idx);
        logic [31:0] tot, img, hd, vd;
        int i;
        tot = 32'(TOTAL);
        img = 32'(IMG);
        hd  = 32'(IMG_HDISP);
        vd  = 32'(IMG_VDISP);
        i   = int'(idx);
        case (i)
            0:              return 8'h42;
            1:              return 8'h4D;
            2, 3, 4, 5:     return tot[8*(i-2) +: 8];
            10:             return 8'd54;
            14:             return 8'd40;
            18, 19, 20, 21: return hd[8*(i-18) +: 8];
            22, 23, 24, 25: return vd[8*(i-22) +: 8];
            26:             return 8'd1;
            28:             return 8'(8 * CHANNELS);
            34, 35, 36, 37: return img[8*(i-34) +: 8];
            default:        return 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        col_d       = col_q;
        line_d      = line_q;
        line_err_d  = line_err_q;
        geom_err_d  = geom_err_q;
        done_d      = done_q;
        pix_addr_d  = pix_addr_q;
        chan_d      = chan_q;
        pad_d       = pad_q;
        byte_cnt_d  = byte_cnt_q;
        gen_done_d  = gen_done_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        ram_we      = 1'b0;

        if (xfer) begin
            out_valid_d = 1'b0;
            if (out_last_q) begin
                out_last_d = 1'b0;
                done_d     = 1'b1;
                state_d    = S_DONE;
            end
        end

        if (adv) begin
            out_valid_d = 1'b1;
            out_last_d  = is_last;
            byte_cnt_d  = byte_cnt_q + 1'b1;
            if (is_last) gen_done_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    state_d     = S_WAIT;
                    done_d      = 1'b0;
                    geom_err_d  = 1'b0;
                    frame_cnt_d = '0;
                end
            end
            S_WAIT: begin
                if (frame_start) begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    if (frame_cnt_q == FW'(START_FRAME - 1)) begin
                        state_d    = S_CAPTURE;
                        col_d      = '0;
                        line_d     = '0;
                        line_err_d = 1'b0;
                    end
                end
            end
            S_CAPTURE: begin
                if (frame_start) begin
                    if (line_q != LW'(IMG_VDISP) || line_err_q) geom_err_d = 1'b1;
                    col_d      = '0;
                    chan_d     = '0;
                    pad_d      = '0;
                    pix_addr_d = '0;
                    byte_cnt_d = '0;
                    gen_done_d = 1'b0;
                    state_d    = (HEADER_EN != 0) ? S_HEADER : S_PIXELS;
                end else if (video_de) begin
                    ram_we = (col_q < CW'(IMG_HDISP)) && (line_q < LW'(IMG_VDISP));
                    // Saturate so over-long lines are dropped instead of wrapping.
                    if (col_q != CW'(IMG_HDISP + 1)) col_d = col_q + 1'b1;
                end else if (de_fall) begin
                    if (col_q != CW'(IMG_HDISP)) line_err_d = 1'b1;
                    col_d = '0;
                    if (line_q != LW'(IMG_VDISP + 1)) line_d = line_q + 1'b1;
                end
            end
            S_HEADER: begin
                if (adv) begin
                    out_data_d = hdr_byte(byte_cnt_q);
                    if (byte_cnt_q == BW'(53)) state_d = S_PIXELS;
                end
            end
            S_PIXELS: begin
                if (adv) begin
                    out_data_d = ram_rd_q[{chan_q, 3'b000} +: 8];
                    if (chan_q == KW'(CHANNELS - 1)) begin
                        chan_d     = '0;
                        pix_addr_d = pix_addr_q + 1'b1;
                        if (col_q == CW'(IMG_HDISP - 1)) begin
                            col_d = '0;
                            if (PAD > 0 && !is_last) state_d = S_PAD;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end else begin
                        chan_d = chan_q + 1'b1;
                    end
                end
            end
            S_PAD: begin
                if (adv) begin
                    out_data_d = 8'h00;
                    if (pad_q == PW'(PAD - 1)) begin
                        pad_d   = '0;
                        state_d = S_PIXELS;
                    end else begin
                        pad_d = pad_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            vs_q        <= 1'b0;
            de_q        <= 1'b0;
            frame_cnt_q <= '0;
            col_q       <= '0;
            line_q      <= '0;
            line_err_q  <= 1'b0;
            geom_err_q  <= 1'b0;
            done_q      <= 1'b0;
            pix_addr_q  <= '0;
            chan_q      <= '0;
            pad_q       <= '0;
            byte_cnt_q  <= '0;
            gen_done_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_q        <= video_vsync;
            de_q        <= video_de;
            frame_cnt_q <= frame_cnt_d;
            col_q       <= col_d;
            line_q      <= line_d;
            line_err_q  <= line_err_d;
            geom_err_q  <= geom_err_d;
            done_q      <= done_d;
            pix_addr_q  <= pix_addr_d;
            chan_q      <= chan_d;
            pad_q       <= pad_d;
            byte_cnt_q  <= byte_cnt_d;
            gen_done_q  <= gen_done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Read follows the next pixel address so ram_rd_q always matches pix_addr_q.
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_wa] <= video_data;
        if (int'(pix_addr_d) < DEPTH) ram_rd_q <= ram[pix_addr_d];
    end

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = done_q;
    assign geom_err  = geom_err_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_video_frame_grabber.sv
// Scoreboard bench for video_frame_grabber: three small configurations share the
// video bus; the active one is selected for the output monitor.
module tb_video_frame_grabber;
    localparam int NI = 3;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            video_vsync, video_hsync, video_de;
    logic [23:0]     video_data;
    logic [NI-1:0]   arm, out_ready, busy, done, geom_err, out_valid, out_last;
    logic [7:0]      out_data [NI];

    int   errors = 0, checks = 0;
    int   sel = 0, cyc = 0;
    int   first_v = -1, last_c = -1, vcount = 0;
    int   exp_idx = 0, exp_total = 0;
    bit   rnd_en = 1'b0;
    exp_t sbq [$];
    logic [7:0] got [$];
    logic [23:0] mram [NI][8];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        video_frame_grabber #(
            .IMG_HDISP  (g == 1 ? 3 : 4),
            .IMG_VDISP  (2),
            .CHANNELS   (3),
            .START_FRAME(g == 2 ? 3 : 1),
            .BOTTOM_UP  (g == 1 ? 0 : 1),
            .HEADER_EN  (1)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .video_vsync(video_vsync),
            .video_hsync(video_hsync),
            .video_de   (video_de),
            .video_data (video_data),
            .arm        (arm[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .geom_err   (geom_err[g]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .out_data   (out_data[g]),
            .out_last   (out_last[g])
        );
    end

    function automatic int hd(input int g);
        return (g == 1) ? 3 : 4;
    endfunction

    function automatic int bu(input int g);
        return (g == 1) ? 0 : 1;
    endfunction

    function automatic logic [23:0] pix(input int seed, input int l, input int c);
        int n;
        n = seed + l * 4 + c;
        return {8'(n + 2), 8'(n + 1), 8'(n)};
    endfunction

    function automatic logic [7:0] hdr(input int i, input int total, input int img, input int h);
        logic [31:0] t, m, w;
        t = total;
        m = img;
        w = h;
        case (i)
            0:              return 8'h42;
            1:              return 8'h4D;
            2, 3, 4, 5:     return t[8*(i-2) +: 8];
            10:             return 8'd54;
            14:             return 8'd40;
            18, 19, 20, 21: return w[8*(i-18) +: 8];
            22:             return 8'd2;
            26:             return 8'd1;
            28:             return 8'd24;
            34, 35, 36, 37: return m[8*(i-34) +: 8];
            default:        return 8'h00;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_vsync();
        video_vsync = 1'b1;
        tick();
        tick();
        video_vsync = 1'b0;
        tick();
    endtask

    task automatic send_line(input int g, input int l, input int npix, input int seed, input bit cap);
        int row;
        row = (bu(g) != 0) ? (1 - l) : l;
        for (int c = 0; c < npix; c++) begin
            video_de    = 1'b1;
            video_hsync = 1'b0;
            video_data  = pix(seed, l, c);
            if (cap && c < hd(g) && l < 2) mram[g][row * hd(g) + c] = video_data;
            tick();
        end
        video_de    = 1'b0;
        video_hsync = 1'b1;
        video_data  = 24'h0;
        tick();
        tick();
    endtask

    task automatic send_frame(input int g, input int nlines, input int npix0, input int seed,
                              input bit cap, input bit arm_mid);
        pulse_vsync();
        if (arm_mid) begin
            arm[g] = 1'b1;
            tick();
            arm[g] = 1'b0;
        end
        tick();
        for (int l = 0; l < nlines; l++)
            send_line(g, l, (l == 0) ? npix0 : hd(g), seed, cap);
    endtask

    task automatic push_exp(input logic [7:0] d);
        exp_t e;
        e.d = d;
        e.l = (exp_idx == exp_total - 1);
        sbq.push_back(e);
        exp_idx++;
    endtask

    task automatic expect_image(input int g);
        int row, pad, img;
        row       = hd(g) * 3;
        pad       = (4 - row % 4) % 4;
        img       = (row + pad) * 2;
        exp_total = img + 54;
        exp_idx   = 0;
        for (int i = 0; i < 54; i++) push_exp(hdr(i, exp_total, img, hd(g)));
        for (int a = 0; a < hd(g) * 2; a++) begin
            for (int k = 0; k < 3; k++) push_exp(mram[g][a][8*k +: 8]);
            if (a % hd(g) == hd(g) - 1)
                for (int p = 0; p < pad; p++) push_exp(8'h00);
        end
    endtask

    task automatic new_stream(input int g);
        sel     = g;
        sbq.delete();
        got.delete();
        first_v = -1;
        last_c  = -1;
        vcount  = 0;
    endtask

    task automatic capture(input int g, input int pre, input int nlines, input int npix0,
                           input int seed, input bit arm_mid);
        arm[g] = 1'b1;
        tick();
        arm[g] = 1'b0;
        for (int f = 0; f < pre; f++) send_frame(g, 2, hd(g), seed - 16 * (pre - f), 1'b0, 1'b0);
        send_frame(g, nlines, npix0, seed, 1'b1, arm_mid);
        expect_image(g);
        pulse_vsync();
    endtask

    task automatic wait_done(input int g, input logic gexp, input int total);
        int n;
        n = 0;
        while (!done[g] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", done[g], 1);
        chk("geom_err", geom_err[g], gexp);
        chk("busy_after_done", busy[g], 0);
        chk("valid_after_done", out_valid[g], 0);
        chk("scoreboard_empty", sbq.size(), 0);
        chk("byte_count", got.size(), total);
        tick();
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_en) out_ready[0] = ($urandom_range(0, 99) >= 30);
    end

    // Output monitor: pops the scoreboard on every transfer and checks stall stability.
    initial begin : monitor
        bit         stall_prev;
        logic [7:0] held_d;
        logic       held_l;
        exp_t       e;
        stall_prev = 1'b0;
        held_d     = 8'h0;
        held_l     = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("stall_valid_held", out_valid[sel], 1);
                    chk("stall_data_held", out_data[sel], held_d);
                    chk("stall_last_held", out_last[sel], held_l);
                end
                if (out_valid[sel]) begin
                    vcount++;
                    if (first_v < 0) first_v = cyc;
                end
                if (out_valid[sel] && out_ready[sel]) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_byte", got.size(), 32'hFFFF_FFFF);
                    end else begin
                        e = sbq.pop_front();
                        chk($sformatf("byte%0d_data", got.size()), out_data[sel], e.d);
                        chk($sformatf("byte%0d_last", got.size()), out_last[sel], e.l);
                    end
                    got.push_back(out_data[sel]);
                    if (out_last[sel]) last_c = cyc;
                end
                stall_prev = out_valid[sel] && !out_ready[sel];
                held_d     = out_data[sel];
                held_l     = out_last[sel];
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        video_vsync = 1'b0;
        video_hsync = 1'b0;
        video_de    = 1'b0;
        video_data  = 24'h0;
        arm         = '0;
        out_ready   = '1;
        for (int g = 0; g < NI; g++)
            for (int a = 0; a < 8; a++) mram[g][a] = 24'h0;
        tick();
        tick();
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("rst_busy%0d", g), busy[g], 0);
            chk($sformatf("rst_done%0d", g), done[g], 0);
            chk($sformatf("rst_geom%0d", g), geom_err[g], 0);
            chk($sformatf("rst_valid%0d", g), out_valid[g], 0);
            chk($sformatf("rst_last%0d", g), out_last[g], 0);
            chk($sformatf("rst_data%0d", g), out_data[g], 0);
        end
        tick();
        rst = 1'b0;
        tick();

        // 1: basic 4x2 bottom-up capture, ready held high
        new_stream(0);
        capture(0, 0, 2, 4, 0, 1'b0);
        chk("t1_busy_streaming", busy[0], 1);
        wait_done(0, 1'b0, 78);
        chk("t1_byte2_total", got[2], 78);
        chk("t1_byte34_img", got[34], 24);
        chk("t1_byte28_bpp", got[28], 24);
        chk("t1_byte54_line1", got[54], 4);
        chk("t1_byte55_line1", got[55], 5);
        chk("t1_byte56_line1", got[56], 6);
        chk("t1_byte66_line0", got[66], 0);
        chk("t1_byte77_last", got[77], 5);
        chk("t1_valid_cycles", vcount, 78);
        chk("t1_valid_span", last_c - first_v + 1, 78);

        // 2: 3x2 top-down with 3 pad bytes per row
        new_stream(1);
        capture(1, 0, 2, 3, 8'h40, 1'b0);
        wait_done(1, 1'b0, 78);
        chk("t2_byte2_total", got[2], 78);
        chk("t2_byte54_line0", got[54], 8'h40);
        chk("t2_byte66_line1", got[66], 8'h44);
        for (int i = 63; i <= 65; i++) chk($sformatf("t2_pad%0d", i), got[i], 0);
        for (int i = 75; i <= 77; i++) chk($sformatf("t2_pad%0d", i), got[i], 0);

        // 3: third frame captured, arm during capture ignored
        new_stream(2);
        capture(2, 2, 2, 4, 8'h30, 1'b1);
        wait_done(2, 1'b0, 78);
        chk("t3_byte54_frame3", got[54], 8'h34);
        chk("t3_byte66_frame3", got[66], 8'h30);

        // 4a: over-long first line
        new_stream(0);
        capture(0, 0, 2, 5, 8'h60, 1'b0);
        wait_done(0, 1'b1, 78);
        chk("t4a_byte66_col0", got[66], 8'h60);
        chk("t4a_byte75_col3", got[75], 8'h63);

        // 4b: single line only; row 0 keeps previous contents
        new_stream(0);
        capture(0, 0, 1, 4, 8'h80, 1'b0);
        wait_done(0, 1'b1, 78);
        chk("t4b_byte66_line0", got[66], 8'h80);

        // 5: random backpressure, same image as test 1
        new_stream(0);
        rnd_en = 1'b1;
        arm[0] = 1'b1;
        tick();
        arm[0] = 1'b0;
        @(negedge clk);
        chk("t5_geom_cleared_by_arm", geom_err[0], 0);
        chk("t5_done_cleared_by_arm", done[0], 0);
        tick();
        send_frame(0, 2, 4, 0, 1'b1, 1'b0);
        expect_image(0);
        pulse_vsync();
        wait_done(0, 1'b0, 78);
        rnd_en       = 1'b0;
        tick();
        out_ready[0] = 1'b1;
        chk("t5_byte54", got[54], 4);

        // 6: reset during pixel streaming, then a fresh capture
        new_stream(0);
        capture(0, 0, 2, 4, 8'h10, 1'b0);
        begin
            int n;
            n = 0;
            while (got.size() < 60 && n < 500) begin
                tick();
                n++;
            end
            chk("t6_reached_pixels", (got.size() >= 60) ? 1 : 0, 1);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_valid", out_valid[0], 0);
        chk("t6_rst_busy", busy[0], 0);
        chk("t6_rst_done", done[0], 0);
        tick();
        rst = 1'b0;
        tick();
        new_stream(0);
        capture(0, 0, 2, 4, 8'h20, 1'b0);
        wait_done(0, 1'b0, 78);
        chk("t6_byte54_after_rst", got[54], 8'h24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
